// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for dmem_arbiter: request/address/data in, grant and one-shot response out.
// The arbiter takes the slave modport; each requester drives the master modport.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [2:0]        size;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        fault;

  modport master (
    output req, we, addr, wdata, size,
    input  gnt, rvalid, rdata, fault
  );

  modport slave (
    input  req, we, addr, wdata, size,
    output gnt, rvalid, rdata, fault
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the data RAM: gnt one cycle after req is sampled, rvalid one cycle later.
// Fixed priority (m0 wins) by default; define DMEM_ARB_ROUND_ROBIN_EN for round-robin between m0 and m1.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wea,
  output logic              ram_rea,
  output logic [2:0]        ram_size,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_l_fault,
  input  logic              ram_s_fault
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        size;
    logic              id;
    logic              mis;
  } acc_t;

  state_t                  r_state;
  acc_t                    r_acc;
  logic [1:0]              r_gnt;
  logic [1:0]              r_rvalid;
  logic [1:0][DATA_W-1:0]  r_rdata;
  logic [1:0][1:0]         r_fault;
  logic                    r_ram_wea;
  logic                    r_ram_rea;

  logic                    w_any;
  logic                    w_win;
  acc_t                    w_acc;
  logic [DATA_W-1:0]       w_rdata;
  logic [1:0]              w_fault;

  assign w_any = m0.req | m1.req;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic r_prio;
  assign w_win = (m0.req && m1.req) ? r_prio : m1.req;
`else
  assign w_win = ~m0.req;
`endif

  always_comb begin
    w_acc = '0;
    if (w_win) begin
      w_acc.we    = m1.we;
      w_acc.addr  = m1.addr;
      w_acc.wdata = m1.wdata;
      w_acc.size  = m1.size;
      w_acc.id    = 1'b1;
    end else begin
      w_acc.we    = m0.we;
      w_acc.addr  = m0.addr;
      w_acc.wdata = m0.wdata;
      w_acc.size  = m0.size;
      w_acc.id    = 1'b0;
    end
    // size[1] = word, size[0] = half, neither = byte (never misaligned)
    if (w_acc.size[1]) begin
      w_acc.mis = |w_acc.addr[1:0];
    end else if (w_acc.size[0]) begin
      w_acc.mis = w_acc.addr[0];
    end else begin
      w_acc.mis = 1'b0;
    end
  end

  assign w_rdata = (r_acc.we || r_acc.mis) ? '0 : ram_dout;
  assign w_fault = {r_acc.mis, r_acc.mis ? 1'b0 : (ram_l_fault | ram_s_fault)};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_gnt     <= '0;
      r_rvalid  <= '0;
      r_rdata   <= '0;
      r_fault   <= '0;
      r_ram_wea <= 1'b0;
      r_ram_rea <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      r_prio    <= 1'b0;
`endif
    end else begin
      r_gnt     <= '0;
      r_rvalid  <= '0;
      r_ram_wea <= 1'b0;
      r_ram_rea <= 1'b0;
      case (r_state)
        ACCESS: begin
          r_rdata[r_acc.id]  <= w_rdata;
          r_fault[r_acc.id]  <= w_fault;
          r_rvalid[r_acc.id] <= 1'b1;
          r_state            <= RESP;
        end
        default: begin
          // IDLE and RESP are both arbitration points, giving back-to-back accesses
          if (w_any) begin
            r_acc        <= w_acc;
            r_gnt[w_win] <= 1'b1;
            r_ram_wea    <= w_acc.we & ~w_acc.mis;
            r_ram_rea    <= ~w_acc.we & ~w_acc.mis;
            r_state      <= ACCESS;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            r_prio       <= ~w_win;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign m0.gnt    = r_gnt[0];
  assign m0.rvalid = r_rvalid[0];
  assign m0.rdata  = r_rdata[0];
  assign m0.fault  = r_fault[0];
  assign m1.gnt    = r_gnt[1];
  assign m1.rvalid = r_rvalid[1];
  assign m1.rdata  = r_rdata[1];
  assign m1.fault  = r_fault[1];

  assign ram_addr  = r_acc.addr;
  assign ram_din   = r_acc.wdata;
  assign ram_size  = r_acc.size;
  assign ram_wea   = r_ram_wea;
  assign ram_rea   = r_ram_rea;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: 128-byte RAM model, directed spec scenarios, then random traffic vs a byte-array reference.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_wea;
  logic        ram_rea;
  logic [2:0]  ram_size;
  logic [31:0] ram_dout;
  logic        ram_l_fault;
  logic        ram_s_fault;
  logic        mem_clr;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .m0          (m0_if.slave),
    .m1          (m1_if.slave),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_wea     (ram_wea),
    .ram_rea     (ram_rea),
    .ram_size    (ram_size),
    .ram_dout    (ram_dout),
    .ram_l_fault (ram_l_fault),
    .ram_s_fault (ram_s_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wea_cnt = 0;
  int rea_cnt = 0;

  function automatic int nbytes(input logic [2:0] s);
    return s[1] ? 4 : (s[0] ? 2 : 1);
  endfunction

  // RAM environment: writes on negedge, combinational read with size/sign handling
  logic [7:0] ram_mem [128];
  always @(negedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 128; i++) ram_mem[i] <= 8'h00;
    end else if (ram_wea && ram_addr < 32'd128) begin
      for (int i = 0; i < nbytes(ram_size); i++)
        ram_mem[ram_addr[6:0] + 7'(i)] <= ram_din[8*i +: 8];
    end
  end

  always_comb begin
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 4; i++)
      if (i < nbytes(ram_size)) v[8*i +: 8] = ram_mem[ram_addr[6:0] + 7'(i)];
    if (!ram_size[2] && nbytes(ram_size) == 1) v = {{24{v[7]}}, v[7:0]};
    if (!ram_size[2] && nbytes(ram_size) == 2) v = {{16{v[15]}}, v[15:0]};
    if (ram_addr >= 32'd128) v = '0;
    ram_dout = v;
  end

  assign ram_l_fault = ram_rea && (ram_addr >= 32'd128);
  assign ram_s_fault = ram_wea && (ram_addr >= 32'd128);

  always @(posedge clk) begin
    if (ram_wea) wea_cnt <= wea_cnt + 1;
    if (ram_rea) rea_cnt <= rea_cnt + 1;
  end

  // Reference memory, updated only by what the bench expects to have been stored
  logic [7:0] exp_mem [128];

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] sz);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (32'(exp_mem[(a + i) % 128]) << (8 * i));
    if (!sz[2] && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic req, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] sz);
    if (p == 0) begin
      m0_if.req = req; m0_if.we = we; m0_if.addr = a; m0_if.wdata = d; m0_if.size = sz;
    end else begin
      m1_if.req = req; m1_if.we = we; m1_if.addr = a; m1_if.wdata = d; m1_if.size = sz;
    end
  endtask

  task automatic access(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] sz, output logic [31:0] rd, output logic [1:0] ft,
                        output int tg, output int tr);
    rd = '0; ft = '0; tg = -1; tr = -1;
    drive(p, 1'b1, we, a, d, sz);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (tg < 0 && (p == 0 ? m0_if.gnt : m1_if.gnt)) begin
        tg = c;
        if (p == 0) m0_if.req = 1'b0; else m1_if.req = 1'b0;
      end
      if (p == 0 ? m0_if.rvalid : m1_if.rvalid) begin
        tr = c;
        rd = (p == 0) ? m0_if.rdata : m1_if.rdata;
        ft = (p == 0) ? m0_if.fault : m1_if.fault;
        break;
      end
    end
    if (p == 0) m0_if.req = 1'b0; else m1_if.req = 1'b0;
  endtask

  // One transaction checked against the reference: latency, data, fault
  task automatic xact(input string tag, input int p, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] sz,
                      output logic [31:0] rd_o, output logic [1:0] ft_o);
    int tg, tr;
    logic mis, oor;
    logic [31:0] exp_rd;
    access(p, we, a, d, sz, rd_o, ft_o, tg, tr);
    mis = sz[1] ? (a[1:0] != 2'b00) : (sz[0] ? a[0] : 1'b0);
    oor = !mis && (a >= 32'd128);
    exp_rd = (we || mis || oor) ? 32'h0 : model_load(a, sz);
    chk({tag, "_lat"}, {32'(tg), 32'(tr)}, {32'd1, 32'd2});
    chk({tag, "_rdata"}, 64'(rd_o), 64'(exp_rd));
    chk({tag, "_fault"}, 64'(ft_o), 64'({mis, oor}));
    if (we && !mis && !oor)
      for (int i = 0; i < nbytes(sz); i++) exp_mem[(a + i) % 128] = d[8*i +: 8];
  endtask

  logic [31:0] rd;
  logic [1:0]  ft;
  int          w0, r0, g0, g1;
  int          gseq[$];
  int          gcyc[$];
  logic [2:0]  sizes [5];

  initial begin
    sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 128; i++) exp_mem[i] = 8'h00;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    rst = 1'b1;
    mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hs", 64'({m0_if.gnt, m0_if.rvalid, m1_if.gnt, m1_if.rvalid, ram_wea, ram_rea}), 64'h0);
    chk("reset_rdata", {m0_if.rdata, m1_if.rdata}, 64'h0);
    chk("reset_ram", {ram_addr, ram_din}, 64'h0);
    chk("reset_misc", 64'({m0_if.fault, m1_if.fault, ram_size}), 64'h0);
    rst = 1'b0;
    mem_clr = 1'b0;
    @(posedge clk); #1;

    // Word store then load, m0
    xact("w_store", 0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, ft);
    xact("w_load", 0, 1'b0, 32'h10, 32'h0, 3'b010, rd, ft);
    chk("w_load_const", 64'({rd, ft}), 64'({32'hDEADBEEF, 2'b00}));

    // Signed vs unsigned byte, m1
    xact("b_store", 1, 1'b1, 32'h21, 32'hABCDEF80, 3'b000, rd, ft);
    xact("b_load_s", 1, 1'b0, 32'h21, 32'h0, 3'b000, rd, ft);
    chk("b_load_s_const", 64'(rd), 64'(32'hFFFFFF80));
    xact("b_load_u", 1, 1'b0, 32'h21, 32'h0, 3'b100, rd, ft);
    chk("b_load_u_const", 64'(rd), 64'(32'h00000080));

    // Misaligned store must not reach RAM
    w0 = wea_cnt;
    xact("mis_store", 0, 1'b1, 32'h12, 32'h12345678, 3'b010, rd, ft);
    chk("mis_store_fault", 64'(ft), 64'(2'b10));
    chk("mis_store_wea", 64'(wea_cnt - w0), 64'd0);
    xact("mis_chk_word", 0, 1'b0, 32'h10, 32'h0, 3'b010, rd, ft);
    chk("mis_word_unchanged", 64'(rd), 64'(32'hDEADBEEF));
    xact("mis_half", 0, 1'b0, 32'h13, 32'h0, 3'b001, rd, ft);
    chk("mis_half_const", 64'({rd, ft}), 64'({32'h0, 2'b10}));

    // Out-of-range load
    r0 = rea_cnt;
    xact("oor_load", 1, 1'b0, 32'h200, 32'h0, 3'b010, rd, ft);
    chk("oor_rea_pulses", 64'(rea_cnt - r0), 64'd1);
    chk("oor_const", 64'({rd, ft}), 64'({32'h0, 2'b01}));

    // Contention: both requests held for 8 cycles
    g0 = 0; g1 = 0;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
    drive(1, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (m0_if.gnt) begin g0++; gseq.push_back(0); gcyc.push_back(c); end
      if (m1_if.gnt) begin g1++; gseq.push_back(1); gcyc.push_back(c); end
    end
    m0_if.req = 1'b0;
    m1_if.req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    chk("cont_counts", {32'(g0), 32'(g1)}, {32'd2, 32'd2});
    for (int i = 0; i < gseq.size(); i++) chk("cont_alternate", 64'(gseq[i]), 64'(i % 2));
`else
    chk("cont_counts", {32'(g0), 32'(g1)}, {32'd4, 32'd0});
`endif
    chk("cont_first", 64'(gcyc.size() > 0 ? gcyc[0] : -1), 64'(1));
    for (int i = 1; i < gcyc.size(); i++) chk("cont_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'd2);

    // Reset at the posedge ending ACCESS of a load
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
    @(posedge clk); #1;
    chk("rst_gnt", 64'(m0_if.gnt), 64'd1);
    m0_if.req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_hs", 64'({m0_if.gnt, m0_if.rvalid, m1_if.gnt, m1_if.rvalid, ram_wea, ram_rea}), 64'h0);
    chk("rst_rdata", {m0_if.rdata, m1_if.rdata}, 64'h0);
    chk("rst_ram", {ram_addr, ram_din}, 64'h0);
    chk("rst_misc", 64'({m0_if.fault, m1_if.fault, ram_size}), 64'h0);
    @(posedge clk); #1;
    chk("rst_idle", 64'({m0_if.rvalid, m0_if.gnt, ram_rea}), 64'h0);
    xact("rst_fresh", 0, 1'b0, 32'h10, 32'h0, 3'b010, rd, ft);
    chk("rst_fresh_const", 64'(rd), 64'(32'hDEADBEEF));

    // Random traffic against the reference memory
    for (int n = 0; n < 40; n++) begin
      int p;
      logic we;
      logic [31:0] a;
      p  = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(128, 511)) : 32'($urandom_range(0, 127));
      xact("rand", p, we, a, $urandom, sizes[$urandom_range(0, 4)], rd, ft);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
